// File: rtl/gate_truth_checker_if.sv
// Handshake and pin bundle for the quad 2-input gate truth-table checker.
// The master side is the controller/chip; the slave side is the checker.
interface gate_truth_checker_if;
  logic       start;
  logic [2:0] gate_type;
  logic [3:0] pin_y_in;
  logic [3:0] pin_a_out;
  logic [3:0] pin_b_out;
  logic       pin_oe;
  logic       busy;
  logic       done;
  logic [3:0] pass_mask;
  logic       error;

  modport master (
    output start, gate_type, pin_y_in,
    input  pin_a_out, pin_b_out, pin_oe, busy, done, pass_mask, error
  );

  modport slave (
    input  start, gate_type, pin_y_in,
    output pin_a_out, pin_b_out, pin_oe, busy, done, pass_mask, error
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Drives the four A/B vectors onto all four gates of a quad 2-input chip,
// samples the synchronised Y pins after a settle time and reports a pass mask.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  gate_truth_checker_if.slave bus
);
  localparam int unsigned   CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;
  typedef enum logic [2:0] {
    GT_NONE = 3'd0, GT_NOT = 3'd1, GT_AND = 3'd2, GT_OR = 3'd3, GT_XOR = 3'd4
  } gate_e;

  function automatic logic expect_y(gate_e t, logic a, logic b);
    case (t)
      GT_AND:  return a & b;
      GT_OR:   return a | b;
      GT_XOR:  return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  state_e        state;
  gate_e         type_q;
  logic [1:0]    vec;
  logic [CW-1:0] cnt;
  logic [3:0]    y_sync1;
  logic [3:0]    y_sync2;
  logic          exp_bit;
  logic [1:0]    vec_next;

  assign exp_bit  = expect_y(type_q, vec[1], vec[0]);
  assign vec_next = vec + 2'd1;

  // NOTE: all state, including the synchroniser and registered outputs, is
  // updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= S_IDLE;
      type_q        <= GT_NONE;
      vec           <= 2'd0;
      cnt           <= '0;
      y_sync1       <= 4'd0;
      y_sync2       <= 4'd0;
      bus.pin_a_out <= 4'd0;
      bus.pin_b_out <= 4'd0;
      bus.pin_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass_mask <= 4'd0;
      bus.error     <= 1'b0;
    end else begin
      y_sync1 <= bus.pin_y_in;
      y_sync2 <= y_sync1;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.gate_type inside {GT_AND, GT_OR, GT_XOR}) begin
              type_q        <= gate_e'(bus.gate_type);
              vec           <= 2'd0;
              cnt           <= '0;
              bus.pass_mask <= 4'b1111;
              bus.error     <= 1'b0;
              bus.pin_a_out <= 4'd0;
              bus.pin_b_out <= 4'd0;
              bus.pin_oe    <= 1'b1;
              bus.busy      <= 1'b1;
              state         <= S_DRIVE;
            end else begin
              // Unsupported type: report immediately without ever driving pins.
              bus.pass_mask <= 4'd0;
              bus.error     <= 1'b1;
              bus.done      <= 1'b1;
              state         <= S_DONE;
            end
          end
        end

        S_DRIVE: begin
          if (cnt == LAST) begin
            bus.pass_mask <= bus.pass_mask & ~(y_sync2 ^ {4{exp_bit}});
            cnt           <= '0;
            if (vec == 2'd3) begin
              bus.pin_a_out <= 4'd0;
              bus.pin_b_out <= 4'd0;
              bus.pin_oe    <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              state         <= S_DONE;
            end else begin
              vec           <= vec_next;
              bus.pin_a_out <= {4{vec_next[1]}};
              bus.pin_b_out <= {4{vec_next[0]}};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker with SETTLE_CYCLES=4 and a
// configurable behavioural quad-gate chip model driving the Y pins.
module tb_gate_truth_checker;
  localparam logic [1:0] FN_AND = 2'd0, FN_OR = 2'd1, FN_XOR = 2'd2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [1:0] model_fn;
  logic [3:0] stuck0_mask;
  logic       flip_g0_on_11;
  logic       use_delay;
  logic [3:0] y_ideal;
  logic [3:0] y_delayed;

  gate_truth_checker_if bus ();

  gate_truth_checker #(.SETTLE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    y_ideal = 4'd0;
    for (int g = 0; g < 4; g++) begin
      case (model_fn)
        FN_AND:  y_ideal[g] = bus.pin_a_out[g] & bus.pin_b_out[g];
        FN_OR:   y_ideal[g] = bus.pin_a_out[g] | bus.pin_b_out[g];
        default: y_ideal[g] = bus.pin_a_out[g] ^ bus.pin_b_out[g];
      endcase
    end
    y_ideal = y_ideal & ~stuck0_mask;
    if (flip_g0_on_11 && bus.pin_a_out[0] && bus.pin_b_out[0]) y_ideal[0] = ~y_ideal[0];
  end

  always_ff @(posedge clk) y_delayed <= y_ideal;

  assign bus.pin_y_in = use_delay ? y_delayed : y_ideal;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input logic [1:0] fn, input logic [3:0] stuck,
                           input logic flip, input logic dly);
    model_fn      = fn;
    stuck0_mask   = stuck;
    flip_g0_on_11 = flip;
    use_delay     = dly;
  endtask

  // Leaves the bench just after the edge that accepted start; gate_type is
  // then scrambled to prove it was latched.
  task automatic do_start(input logic [2:0] t);
    bus.gate_type = t;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.gate_type = 3'd7;
  endtask

  task automatic check_run(input string name, input logic [3:0] exp_mask, input bit poke);
    logic [1:0]  v;
    logic [10:0] obs, expv;
    logic [14:0] obs2, expv2;
    int          done_count;
    for (int c = 0; c < 16; c++) begin
      if (poke && (c == 2 || c == 15)) bus.start = 1'b1;
      v    = 2'(c / 4);
      obs  = {bus.busy, bus.pin_oe, bus.done, bus.pin_a_out, bus.pin_b_out};
      expv = {1'b1, 1'b1, 1'b0, {4{v[1]}}, {4{v[0]}}};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s drive c=%0d: got %b expected %b", name, c, obs, expv);
      end
      tick();
      bus.start = 1'b0;
    end
    obs2  = {bus.busy, bus.pin_oe, bus.done, bus.pin_a_out, bus.pin_b_out, bus.pass_mask, bus.error};
    expv2 = {1'b0, 1'b0, 1'b1, 4'd0, 4'd0, exp_mask, 1'b0};
    n_checks++;
    if (obs2 !== expv2) begin
      n_fail++;
      $display("FAIL %s done cycle: got %b expected %b", name, obs2, expv2);
    end
    tick();
    obs2  = {bus.busy, bus.pin_oe, bus.done, bus.pin_a_out, bus.pin_b_out, bus.pass_mask, bus.error};
    expv2 = {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, exp_mask, 1'b0};
    n_checks++;
    if (obs2 !== expv2) begin
      n_fail++;
      $display("FAIL %s after done: got %b expected %b", name, obs2, expv2);
    end
    if (poke) begin
      done_count = 0;
      for (int c = 0; c < 10; c++) begin
        if (bus.done === 1'b1 || bus.busy === 1'b1) done_count++;
        tick();
      end
      n_checks++;
      if (done_count !== 0) begin
        n_fail++;
        $display("FAIL %s extra activity: got %0d busy/done cycles expected 0", name, done_count);
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.gate_type = 3'd0;
    set_model(FN_AND, 4'd0, 1'b0, 1'b0);
    repeat (3) tick();
    obs = {bus.busy, bus.pin_oe, bus.done, bus.pin_a_out, bus.pin_b_out, bus.pass_mask, bus.error};
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL reset values: got %b expected 0", obs);
    end
    bus.gate_type = 3'd2;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    obs = {bus.busy, bus.pin_oe, bus.done, bus.pin_a_out, bus.pin_b_out, bus.pass_mask, bus.error};
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL reset beats start: got %b expected 0", obs);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_and_ideal();
    set_model(FN_AND, 4'd0, 1'b0, 1'b0);
    do_start(3'd2);
    check_run("and_ideal", 4'b1111, 1'b0);
  endtask

  task automatic test_or_stuck();
    set_model(FN_OR, 4'b0100, 1'b0, 1'b0);
    do_start(3'd3);
    check_run("or_stuck_g2", 4'b1011, 1'b0);
  endtask

  task automatic test_xor_fault();
    set_model(FN_XOR, 4'd0, 1'b1, 1'b0);
    do_start(3'd4);
    check_run("xor_g0_bad_11", 4'b1110, 1'b0);
  endtask

  task automatic test_wrong_type();
    set_model(FN_XOR, 4'd0, 1'b0, 1'b0);
    do_start(3'd2);
    check_run("xor_chip_as_and", 4'b0000, 1'b0);
  endtask

  task automatic test_unsupported(input logic [2:0] t);
    logic [7:0] obs;
    do_start(t);
    obs = {bus.busy, bus.pin_oe, bus.done, bus.error, bus.pass_mask};
    n_checks++;
    if (obs !== 8'b0011_0000) begin
      n_fail++;
      $display("FAIL unsupported type %0d done: got %b expected 00110000", t, obs);
    end
    tick();
    obs = {bus.busy, bus.pin_oe, bus.done, bus.error, bus.pass_mask};
    n_checks++;
    if (obs !== 8'b0001_0000) begin
      n_fail++;
      $display("FAIL unsupported type %0d held: got %b expected 00010000", t, obs);
    end
  endtask

  task automatic test_delay();
    set_model(FN_AND, 4'd0, 1'b0, 1'b1);
    do_start(3'd2);
    check_run("and_delayed_y", 4'b1111, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    logic [14:0] obs;
    int          done_count;
    set_model(FN_AND, 4'd0, 1'b0, 1'b0);
    do_start(3'd2);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    obs = {bus.busy, bus.pin_oe, bus.done, bus.pin_a_out, bus.pin_b_out, bus.pass_mask, bus.error};
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL mid-run reset: got %b expected 0", obs);
    end
    reset = 1'b0;
    done_count = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_count++;
      tick();
    end
    n_checks++;
    if (done_count !== 0) begin
      n_fail++;
      $display("FAIL post-reset quiet: got %0d active cycles expected 0", done_count);
    end
    do_start(3'd2);
    check_run("after_reset", 4'b1111, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_model(FN_OR, 4'd0, 1'b0, 1'b0);
    do_start(3'd3);
    check_run("extra_starts", 4'b1111, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_and_ideal();
    test_or_stuck();
    test_xor_fault();
    test_wrong_type();
    test_unsupported(3'd1);
    test_unsupported(3'd0);
    test_delay();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Exhaustive truth-table verifier for quad 2-input logic chips (AND/OR/XOR), run after the gate finder has classified the device. On `start` it drives all four input vectors onto the A/B pins of all four gates at once and waits a settle time per vector. It samples the synchronised Y pins and reports a per-gate pass mask. It owns only the A/B drive values and one output-enable; the top level maps these onto GPIO_0 tristates.

## Interface
- `SETTLE_CYCLES`, 50000, clocks each vector is held before Y is sampled (≥3; 1 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a test run; sampled only in IDLE.
- `gate_type`  in  3  0=NONE, 1=NOT, 2=AND, 3=OR, 4=XOR; latched on accepted `start`.
- `pin_y_in`  in  4  raw asynchronous gate outputs Y[3:0].
- `pin_a_out`  out  4  A-input drive values, one bit per gate.
- `pin_b_out`  out  4  B-input drive values, one bit per gate.
- `pin_oe`  out  1  1 = top level drives A/B pins; 0 = A/B pins high-Z.
- `busy`  out  1  test run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass_mask`  out  4  bit g = gate g matched on every vector; valid from `done`, held until the next accepted `start`.
- `error`  out  1  last `start` carried an unsupported `gate_type`; held like `pass_mask`.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: `pin_oe`=0 and `busy`=0. `start`=1 with `gate_type` in {2,3,4}:
  - latch the type;
  - set vector index v=0 and settle counter=0;
  - set `pass_mask`=4'b1111 and `error`=0;
  - go to DRIVE.
- IDLE with `start`=1 and any other `gate_type`: set `error`=1 and `pass_mask`=0, go to DONE. `pin_oe` is never asserted on this path.
- DRIVE:
  - `pin_oe`=1, `busy`=1.
  - `pin_a_out`={4{v[1]}}, `pin_b_out`={4{v[0]}}; vector order 00, 01, 10, 11.
  - The counter increments every cycle.
  - When the counter equals SETTLE_CYCLES-1: compare the synchronised Y for each gate g with the expected value f(v[1],v[0]). AND: a&b; OR: a|b; XOR: a^b. On mismatch clear `pass_mask[g]`.
  - Then reset the counter. If v<3, increment v. If v=3, go to DONE.
- DONE, exactly one cycle: `done`=1, `busy`=0, `pin_oe`=0, A/B outputs=0. Return to IDLE.
- `pin_y_in` passes through a 2-flop synchroniser, reset to 0. Comparison uses only the second-stage value.
- `pass_mask` bits only clear during a run, never set. One failing vector fails the gate for the whole run.
- `gate_type` changes after the accepted `start` have no effect on the run.
- `start` in DRIVE or DONE is ignored; nothing is queued.

## Timing
- Reset values: `pin_a_out`=0, `pin_b_out`=0, `pin_oe`=0, `busy`=0, `done`=0, `pass_mask`=0, `error`=0. State=IDLE, synchroniser flops=0.
- `reset` wins over `start` in the same cycle.
- `reset` during DRIVE: on the next edge all outputs take reset values and the A/B pins are released. No `done` pulse is produced.
- `start` high at edge k (supported type):
  - `busy`=1, `pin_oe`=1 and vector 00 are visible after edge k.
  - Vector v is driven for exactly SETTLE_CYCLES cycles. The sample is taken at edge k+(v+1)·SETTLE_CYCLES.
  - `done`=1 and `busy`=0 follow edge k+4·SETTLE_CYCLES.
  - `pass_mask` is final in the same cycle as `done`.
- Unsupported type with `start` at edge k: `done`=1 and `error`=1 in the cycle after edge k; `busy` stays 0.
- Y must be stable 2 cycles before the sample edge to be seen, so the usable settle time is SETTLE_CYCLES-2 clocks.
- Counter width: $clog2(SETTLE_CYCLES). It never wraps, because it is cleared at SETTLE_CYCLES-1.

## Test plan
All scenarios use SETTLE_CYCLES=4.
- Ideal AND chip model (Y=A&B, zero delay), `gate_type`=2, `start` pulse at edge 0 -> A/B step 00,01,10,11 every 4 cycles; `done` after edge 16; `pass_mask`=4'b1111, `error`=0, `pin_oe` back to 0 with `done`.
- OR model with gate 2 Y stuck at 0, `gate_type`=3 -> `pass_mask`=4'b1011. XOR model with gate 0 wrong only on vector 11, `gate_type`=4 -> `pass_mask`=4'b1110.
- Ideal XOR model but `gate_type`=2 (AND) -> vectors 01 and 10 mismatch on every gate -> `pass_mask`=4'b0000, `error`=0.
- `gate_type`=1 and separately `gate_type`=0, `start` -> `done`=1 and `error`=1 one cycle later, `pass_mask`=0, `pin_oe` never 1.
- Model Y delayed 1 cycle behind A/B -> still `pass_mask`=4'b1111.
- Assert `reset` at cycle 9 of a run -> all outputs 0 the next cycle and no `done`. A fresh `start` then completes normally in 16 cycles.
- Extra `start` pulses at cycles 3 and 16 of a run -> ignored; exactly one `done`.
